// File: rtl/tdt_dm_pulse_evt_arb.sv
// ---------------------------------------------------------------------------
// tdt_dm_pulse_evt_arb
//
// Destination-domain event collector for a bank of pulse synchronizers.
// Each channel counts its single-cycle pulses in a saturating counter, so no
// event is lost while the consumer is busy. Pending events are presented one
// at a time on a registered valid/ready interface. A round-robin arbiter
// picks which channel is presented next. When a counter is full and another
// pulse arrives, that event is dropped and a sticky overflow bit is set.
//
// Ports
//   dst_clk      in   block clock (destination domain)
//   dst_rst_b    in   asynchronous active-low reset
//   pulse_in     in   [CH_NUM]  one-cycle event pulses, one bit per channel
//   evt_valid    out  event presented on evt_id
//   evt_ready    in   consumer accepts (transfer on evt_valid & evt_ready)
//   evt_id       out  [ID_W]    channel of the presented event
//   evt_pending  out  [CH_NUM]  channel has a nonzero count (the presented
//                               event is not included)
//   ovf_sticky   out  [CH_NUM]  an event on that channel was dropped
//   ovf_clr      in   [CH_NUM]  write-1-to-clear for ovf_sticky
// ---------------------------------------------------------------------------
module tdt_dm_pulse_evt_arb #(
   parameter int CH_NUM = 4,
   parameter int CNT_W  = 4,
   parameter int ID_W   = 2
) (
   input  logic              dst_clk,
   input  logic              dst_rst_b,
   input  logic [CH_NUM-1:0] pulse_in,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [ID_W-1:0]   evt_id,
   output logic [CH_NUM-1:0] evt_pending,
   output logic [CH_NUM-1:0] ovf_sticky,
   input  logic [CH_NUM-1:0] ovf_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]  cnt     [CH_NUM];
   logic [CNT_W-1:0]  cnt_nxt [CH_NUM];
   logic [ID_W-1:0]   last_id;
   logic [CH_NUM-1:0] req;
   logic [CH_NUM-1:0] dec;
   logic [CH_NUM-1:0] ovf_set;
   logic [ID_W-1:0]   gnt;
   logic              found;
   logic              load;

   // Requests come from registered counts only, so nothing from an input
   // reaches an output combinationally.
   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         req[i] = (cnt[i] != '0);
      end
   end

   // Round-robin search: offsets 1..CH_NUM from last_id; the first channel
   // found with a request wins. Offset CH_NUM is last_id itself, so it has
   // the lowest priority.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      for (int k = 1; k <= CH_NUM; k++) begin
         for (int i = 0; i < CH_NUM; i++) begin
            if (!found && req[i] && (((int'(last_id) + k) % CH_NUM) == i)) begin
               found = 1'b1;
               gnt   = ID_W'(i);
            end
         end
      end
   end

   // The output register may be refilled when it is empty or being consumed.
   assign load = (!evt_valid || evt_ready) && found;

   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         dec[i] = load && (gnt == ID_W'(i));
      end
   end

   // An increment and a decrement in the same cycle cancel out, even at
   // full scale. That case is not an overflow.
   always_comb begin
      ovf_set = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         cnt_nxt[i] = cnt[i];
         if (pulse_in[i] && !dec[i]) begin
            if (cnt[i] == CNT_MAX) begin
               ovf_set[i] = 1'b1;
            end else begin
               cnt_nxt[i] = cnt[i] + 1'b1;
            end
         end else if (!pulse_in[i] && dec[i]) begin
            cnt_nxt[i] = cnt[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge dst_clk or negedge dst_rst_b) begin
      if (!dst_rst_b) begin
         evt_valid  <= 1'b0;
         evt_id     <= '0;
         last_id    <= ID_W'(CH_NUM - 1);
         ovf_sticky <= '0;
         for (int i = 0; i < CH_NUM; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         if (load) begin
            evt_valid <= 1'b1;
            evt_id    <= gnt;
            last_id   <= gnt;
         end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
         end
         // A set in the same cycle takes priority over a clear.
         ovf_sticky <= ovf_set | (ovf_sticky & ~ovf_clr);
         for (int i = 0; i < CH_NUM; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

   assign evt_pending = req;

endmodule

// File: tb/tb_tdt_dm_pulse_evt_arb.sv
module tb_tdt_dm_pulse_evt_arb;

   localparam int CH   = 4;
   localparam int CW   = 4;
   localparam int IW   = 2;
   localparam int MAXC = (1 << CW) - 1;

   logic          dst_clk = 1'b0;
   logic          dst_rst_b = 1'b0;
   logic [CH-1:0] pulse_in = '0;
   logic          evt_valid;
   logic          evt_ready = 1'b0;
   logic [IW-1:0] evt_id;
   logic [CH-1:0] evt_pending;
   logic [CH-1:0] ovf_sticky;
   logic [CH-1:0] ovf_clr = '0;

   tdt_dm_pulse_evt_arb #(.CH_NUM(CH), .CNT_W(CW), .ID_W(IW)) dut (
      .dst_clk     (dst_clk),
      .dst_rst_b   (dst_rst_b),
      .pulse_in    (pulse_in),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_id      (evt_id),
      .evt_pending (evt_pending),
      .ovf_sticky  (ovf_sticky),
      .ovf_clr     (ovf_clr)
   );

   always #5 dst_clk = ~dst_clk;

   int checks = 0;
   int failures = 0;

   // Reference model: pending counts as plain integers, clamped at full scale.
   int m_cnt [CH];
   bit m_ovf [CH];
   bit m_vld;
   int m_id;
   int m_last;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < CH; i++) begin
         m_cnt[i] = 0;
         m_ovf[i] = 0;
      end
      m_vld  = 0;
      m_id   = 0;
      m_last = CH - 1;
   endfunction

   function automatic void model_step(input bit [CH-1:0] p, input bit r, input bit [CH-1:0] c);
      int g;
      int n;
      g = -1;
      if (!m_vld || r) begin
         for (int off = 1; off <= CH; off++) begin
            if (g < 0 && m_cnt[(m_last + off) % CH] > 0) g = (m_last + off) % CH;
         end
      end
      for (int i = 0; i < CH; i++) begin
         n = m_cnt[i] + int'(p[i]) - ((g == i) ? 1 : 0);
         if (n > MAXC) begin
            m_cnt[i] = MAXC;
            m_ovf[i] = 1;
         end else begin
            m_cnt[i] = n;
            if (c[i]) m_ovf[i] = 0;
         end
      end
      if (g >= 0) begin
         m_vld  = 1;
         m_id   = g;
         m_last = g;
      end else if (m_vld && r) begin
         m_vld = 0;
      end
   endfunction

   function automatic logic [CH-1:0] m_pend();
      logic [CH-1:0] v;
      for (int i = 0; i < CH; i++) v[i] = (m_cnt[i] != 0);
      return v;
   endfunction

   function automatic logic [CH-1:0] m_ovfv();
      logic [CH-1:0] v;
      for (int i = 0; i < CH; i++) v[i] = m_ovf[i];
      return v;
   endfunction

   task automatic compare_all();
      chk("evt_valid", 32'(evt_valid), 32'(m_vld));
      chk("evt_id", 32'(evt_id), 32'(m_id));
      chk("evt_pending", 32'(evt_pending), 32'(m_pend()));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(m_ovfv()));
   endtask

   // Drive one clock cycle of inputs, advance the model at the edge, and
   // compare on the following falling edge.
   task automatic cycle(input logic [CH-1:0] p, input logic r, input logic [CH-1:0] c);
      pulse_in  = p;
      evt_ready = r;
      ovf_clr   = c;
      @(posedge dst_clk);
      model_step(p, r, c);
      @(negedge dst_clk);
      pulse_in = '0;
      ovf_clr  = '0;
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge dst_clk);
      #2;
      dst_rst_b = 1'b0;
      #1;
      model_reset();
      chk("rst_valid", 32'(evt_valid), 32'd0);
      chk("rst_pending", 32'(evt_pending), 32'd0);
      chk("rst_ovf", 32'(ovf_sticky), 32'd0);
      chk("rst_id", 32'(evt_id), 32'd0);
      repeat (2) @(negedge dst_clk);
      dst_rst_b = 1'b1;
   endtask

   int acc1;
   logic [CH-1:0] rp;
   logic rr;
   logic [CH-1:0] rc;

   initial begin
      model_reset();
      repeat (3) @(negedge dst_clk);
      chk("rst_valid", 32'(evt_valid), 32'd0);
      chk("rst_id", 32'(evt_id), 32'd0);
      chk("rst_pending", 32'(evt_pending), 32'd0);
      chk("rst_ovf", 32'(ovf_sticky), 32'd0);
      dst_rst_b = 1'b1;

      // Single event: two-cycle latency, pending visible only for one cycle.
      cycle('0, 1'b1, '0);
      cycle(4'b0100, 1'b1, '0);
      chk("single_pend", 32'(evt_pending), 32'h4);
      chk("single_vld0", 32'(evt_valid), 32'd0);
      cycle('0, 1'b1, '0);
      chk("single_vld", 32'(evt_valid), 32'd1);
      chk("single_id", 32'(evt_id), 32'd2);
      chk("single_pend0", 32'(evt_pending), 32'd0);
      cycle('0, 1'b1, '0);
      chk("single_done", 32'(evt_valid), 32'd0);

      // Fairness: all four channels at once come out in order. The previous
      // grant was channel 2, so move the pointer to 3 first for a clean 0..3.
      do_reset();
      cycle(4'hF, 1'b1, '0);
      for (int k = 0; k < CH; k++) begin
         cycle('0, 1'b1, '0);
         chk("fair_vld", 32'(evt_valid), 32'd1);
         chk("fair_id", 32'(evt_id), 32'(k));
      end
      cycle('0, 1'b1, '0);
      cycle(4'b1001, 1'b1, '0);
      cycle('0, 1'b1, '0);
      chk("fair2_id0", 32'(evt_id), 32'd0);
      cycle('0, 1'b1, '0);
      chk("fair2_id3", 32'(evt_id), 32'd3);
      cycle('0, 1'b1, '0);

      // Stall: id held while ready is low, channel 0 accumulates underneath.
      cycle(4'b0010, 1'b0, '0);
      cycle('0, 1'b0, '0);
      chk("stall_id_start", 32'(evt_id), 32'd1);
      for (int k = 0; k < 5; k++) begin
         cycle(4'b0001, 1'b0, '0);
         chk("stall_id", 32'(evt_id), 32'd1);
         chk("stall_vld", 32'(evt_valid), 32'd1);
      end
      cycle('0, 1'b1, '0);
      chk("stall_next", 32'(evt_id), 32'd0);
      repeat (8) cycle('0, 1'b1, '0);
      chk("stall_drained", 32'(evt_valid), 32'd0);

      // Saturation on channel 1: 17 pulses with ready low.
      repeat (17) cycle(4'b0010, 1'b0, '0);
      chk("sat_ovf", 32'(ovf_sticky[1]), 32'd1);
      acc1 = 0;
      for (int k = 0; k < 20; k++) begin
         if (evt_valid && evt_id == 2'd1) acc1++;
         cycle('0, 1'b1, '0);
      end
      chk("sat_drain", 32'(acc1), 32'd16);
      chk("sat_ovf_kept", 32'(ovf_sticky[1]), 32'd1);
      cycle('0, 1'b1, 4'b0010);
      chk("sat_clr", 32'(ovf_sticky[1]), 32'd0);

      // Increment and decrement together at full scale.
      repeat (16) cycle(4'b0001, 1'b0, '0);
      chk("incdec_pre_ovf", 32'(ovf_sticky[0]), 32'd0);
      cycle(4'b0001, 1'b1, '0);
      chk("incdec_ovf", 32'(ovf_sticky[0]), 32'd0);
      chk("incdec_vld", 32'(evt_valid), 32'd1);
      cycle(4'b0001, 1'b0, 4'b0001);
      chk("setclr_ovf", 32'(ovf_sticky[0]), 32'd1);

      // Reset in the middle of a burst.
      cycle(4'b0110, 1'b0, '0);
      do_reset();
      repeat (5) cycle('0, 1'b1, '0);
      chk("post_rst_idle", 32'(evt_valid), 32'd0);

      // Randomized traffic in phases of varying density and back-pressure.
      for (int ph = 0; ph < 6; ph++) begin
         for (int k = 0; k < 500; k++) begin
            rp = '0;
            for (int i = 0; i < CH; i++) rp[i] = ($urandom_range(0, 7) < ph + 1);
            rr = ($urandom_range(0, 5) >= (ph % 3) * 2);
            rc = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
            cycle(rp, rr, rc);
         end
         if (ph == 2) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tdt_dm_pulse_evt_arb.md
# tdt_dm_pulse_evt_arb

Destination-domain event collector that sits directly downstream of a bank of `tdt_dm_pulse_sync` instances in the debug module. It counts the single-cycle `dst_pulse` events of up to `CH_NUM` channels in per-channel counters so that no event is lost while the consumer is busy. It presents the events one at a time on a registered valid/ready interface, arbitrated round-robin. Counter saturation is flagged per channel with a sticky, software-clearable overflow bit.

## Interface
- `CH_NUM`, 4, number of pulse channels (2..8)
- `CNT_W`, 4, per-channel pending-count width; max count `2^CNT_W-1`
- `ID_W`, 2, channel-id width; `2^ID_W >= CH_NUM` required
- `dst_clk`  in  1  block clock (destination domain of the pulse synchronizers)
- `dst_rst_b`  in  1  asynchronous, active-low reset
- `pulse_in`  in  CH_NUM  one-cycle event pulses, one bit per channel
- `evt_valid`  out  1  event presented
- `evt_ready`  in  1  consumer accepts; transfer when `evt_valid & evt_ready`
- `evt_id`  out  ID_W  channel of presented event
- `evt_pending`  out  CH_NUM  bit i = `cnt[i] != 0`; excludes the event held on the output
- `ovf_sticky`  out  CH_NUM  bit i set when a channel-i event was dropped
- `ovf_clr`  in  CH_NUM  write-1-to-clear for `ovf_sticky`; single-cycle pulse

## Operation
- State per channel: `cnt[i]` (CNT_W bits) and `ovf_sticky[i]`.
- Shared state: output register (`evt_valid`, `evt_id`) and round-robin pointer `last_id`.
- Reset values:
  - `cnt` = 0, `ovf_sticky` = 0
  - `evt_valid` = 0, `evt_id` = 0
  - `last_id` = CH_NUM-1, so channel 0 has first priority.
- Load condition: `load = (!evt_valid | evt_ready) & (|req)`, where `req[i] = (cnt[i] != 0)`, taken from registered counts only.
- Grant: the first channel with `req` set, searching `last_id+1, last_id+2, ...` and wrapping modulo CH_NUM.
- On `load` with grant g:
  - `evt_valid` <= 1, `evt_id` <= g, `last_id` <= g
  - `cnt[g]` is decremented.
- Output with no `load`:
  - If `evt_valid & evt_ready`, then `evt_valid` <= 0.
  - Otherwise `evt_valid` and `evt_id` hold.
  - While `evt_valid=1 & evt_ready=0`, `evt_id` must not change.
- Counter update for each i, with `inc = pulse_in[i]` and `dec = load & (g == i)`:
  - inc only, `cnt < max`: `cnt+1`
  - inc only, `cnt == max`: unchanged, and `ovf_sticky[i]` <= 1 (event dropped)
  - dec only: `cnt-1`
  - inc and dec together: unchanged, including at max; no overflow.
- `dec` only occurs when `cnt != 0`, so the counter never underflows.
- `ovf_sticky[i]`: set has priority over `ovf_clr[i]` in the same cycle; otherwise `ovf_clr[i]=1` clears it.
- `pulse_in` is sampled every cycle; a multi-cycle high counts once per cycle (the upstream synchronizer guarantees single-cycle pulses).
- Asynchronous reset mid-operation: all state returns to reset values immediately, pending and presented events are discarded, and no `evt_valid` appears until new pulses arrive after deassertion.

## Timing
- Latency, idle block: `pulse_in[i]` high in cycle N → `cnt[i]=1` in N+1 → `evt_valid=1`, `evt_id=i` in N+2.
- Throughput: with `evt_ready` held high and requests present, one event is accepted per cycle with no bubbles.
- Capacity per channel: `2^CNT_W-1` in the counter plus at most one event in the output register.
- `evt_pending` and `ovf_sticky` are direct register decodes with zero added latency.
- `ovf_sticky` is set in the cycle after the dropping pulse.
- All outputs are registered or decoded from registers only; there is no combinational path from any input to any output.

## Test plan
- Single event: pulse `pulse_in[2]` in cycle 10 with `evt_ready=1` → `evt_valid=1`, `evt_id=2` in cycle 12 only; `evt_pending[2]=1` in cycle 11 only.
- Fairness: pulse all 4 channels in cycle 10, `evt_ready=1` → `evt_id` = 0, 1, 2, 3 in cycles 12–15. Then pulse ch0 and ch3 together → ch0 is granted first, because `last_id=3`.
- Stall: hold `evt_ready=0` for 5 cycles while `evt_valid=1`, `evt_id=1` → id stable. Concurrent pulses on ch0 raise `cnt[0]` without changing the output. After ready rises, ch0 is granted next.
- Saturation (`CNT_W=4`):
  - Stimulus: `evt_ready=0`, 17 consecutive ch1 pulses.
  - First event goes to the output register and `cnt[1]` stops at 15.
  - The 17th pulse sets `ovf_sticky[1]`.
  - Raising ready drains exactly 16 id-1 events.
  - `ovf_clr[1]` then clears the flag.
- Simultaneous inc/dec at max: `cnt[0]=15`, output empty, `pulse_in[0]` in the grant cycle → `cnt[0]` stays 15 and `ovf_sticky[0]` stays 0. A concurrent set and `ovf_clr` on the same channel leaves the bit set.
- Reset mid-burst: assert `dst_rst_b=0` with `evt_valid=1` and counts nonzero → `evt_valid`, `evt_pending` and `ovf_sticky` read 0 immediately. After release, no event appears without a new pulse.
